// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register controller: FSM state encoding
// and the default register-file geometry and device ID.
package i2c_pkg;

    localparam int         NUM_REGS_DEFAULT = 8;
    localparam logic [7:0] DEV_ID_DEFAULT   = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GET_PTR    = 2'd1,
        ST_WRITE_DATA = 2'd2,
        ST_DISCARD    = 2'd3
    } state_t;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for a level input. The history flop resets to 1 so a
// level that is already high when reset releases produces no pulse.
module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic pulse
);

    logic prev_reg;

    // Remember last cycle's level.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg <= 1'b1;
        end else begin
            prev_reg <= sig;
        end
    end

    assign pulse = sig & ~prev_reg;

endmodule

// File: rtl/i2c_reg_ctrl.sv
// I2C register controller: the first byte after a start selects a register
// pointer, following bytes are written to auto-incrementing registers.
// Register 0 holds a read-only device ID; register 7 written with 8'h00
// clears the sticky error flag.
module i2c_reg_ctrl
    import i2c_pkg::*;
#(
    parameter int         NUM_REGS = NUM_REGS_DEFAULT,
    parameter logic [7:0] DEV_ID   = DEV_ID_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    output logic [8*NUM_REGS-1:0] regs_o,
    output logic                  wr_strobe_o,
    output logic [2:0]            wr_addr_o,
    output logic                  busy_o,
    output logic                  err_o
);

    state_t     state_reg, state_next;
    logic [2:0] ptr_reg, ptr_next;
    logic       err_reg, err_next;
    logic       wr_strobe_reg, wr_strobe_next;
    logic [2:0] wr_addr_reg, wr_addr_next;
    logic       wr_en;
    logic       byte_event;
    logic [7:0] regs_reg [NUM_REGS];

    edge_det u_edge_det (
        .clk   (clk),
        .reset (reset),
        .sig   (rx_valid_i),
        .pulse (byte_event)
    );

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= 3'd0;
            err_reg       <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= 3'd0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            err_reg       <= err_next;
            wr_strobe_reg <= wr_strobe_next;
            wr_addr_reg   <= wr_addr_next;
        end
    end

    // Next-state logic: start overrides everything (the byte is dropped);
    // otherwise the byte is handled in the current state and stop then
    // forces IDLE, so a byte coincident with stop is still written.
    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        err_next       = err_reg;
        wr_strobe_next = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_en          = 1'b0;
        if (start_i) begin
            state_next = ST_GET_PTR;
        end else begin
            if (byte_event) begin
                case (state_reg)
                    ST_GET_PTR: begin
                        if (rx_data_i[7:3] == 5'd0) begin
                            ptr_next   = rx_data_i[2:0];
                            state_next = ST_WRITE_DATA;
                        end else begin
                            err_next   = 1'b1;
                            state_next = ST_DISCARD;
                        end
                    end
                    ST_WRITE_DATA: begin
                        if (ptr_reg == 3'd0) begin
                            // Device ID is read-only: flag it, skip the write.
                            err_next = 1'b1;
                        end else begin
                            wr_en          = 1'b1;
                            wr_strobe_next = 1'b1;
                            wr_addr_next   = ptr_reg;
                            if (ptr_reg == 3'd7 && rx_data_i == 8'h00) begin
                                err_next = 1'b0;
                            end
                        end
                        ptr_next = ptr_reg + 3'd1;
                    end
                    default: begin
                    end
                endcase
            end
            if (stop_i) begin
                state_next = ST_IDLE;
            end
        end
    end

    // Register file, one flop group per register, flattened onto regs_o.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            always_ff @(posedge clk) begin
                if (reset) begin
                    regs_reg[gi] <= (gi == 0) ? DEV_ID : 8'h00;
                end else if (gi != 0 && wr_en && ptr_reg == 3'(gi)) begin
                    regs_reg[gi] <= rx_data_i;
                end
            end
            assign regs_o[8*gi +: 8] = regs_reg[gi];
        end
    endgenerate

    assign wr_strobe_o = wr_strobe_reg;
    assign wr_addr_o   = wr_addr_reg;
    assign busy_o      = (state_reg != ST_IDLE);
    assign err_o       = err_reg;

endmodule
